voq_rr_scheduler: RTL

Downstream read scheduler for the shared-buffer VOQ. Watches the per-queue empty flags, picks a non-empty queue by round-robin with a bounded burst per queue, drives the VOQ read port with the required two-cycle read/pop sequence, and delivers each word with its queue tag on a valid/ready output stream through a 2-entry output buffer. It is the only master of the VOQ read port.

---
 rtl/voq_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/voq_rr_scheduler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/voq_pkg.sv
// Types and helpers shared by the VOQ and its read-side schedulers.
package voq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_POP  = 2'd2
  } sched_state_e;

  // Client index width; never collapses to zero bits.
  function automatic int client_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requesting index after last_grant, wrapping at N-1.
module rr_arbiter
  import voq_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = client_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] last_grant,
  output logic [CW-1:0] grant,
  output logic          any_valid
);

  logic [CW-1:0] idx;

  // Offsets 1..N, so last_grant itself is considered last.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = 1; i <= N; i++) begin
      idx = CW'((int'(last_grant) + i) % N);
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        grant     = idx;
      end
    end
  end

endmodule

// File: rtl/voq_rr_scheduler.sv
// VOQ read scheduler: round-robin with bounded bursts, two-cycle read/pop,
// words delivered with their queue tag through a 2-entry output buffer.
//   state | meaning
//   IDLE  | wait for a non-empty queue and a free buffer slot, pick grant
//   READ  | voq_rd_en high for the granted queue
//   POP   | VOQ pops, read data pushed into the output buffer
module voq_rr_scheduler
  import voq_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int QUEUE_NUB  = 4,
  parameter int BURST      = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [QUEUE_NUB-1:0]             voq_queue_empty,
  output logic                             voq_rd_en,
  output logic [client_w(QUEUE_NUB)-1:0]   voq_rd_client,
  input  logic [DATA_WIDTH-1:0]            voq_rd_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [client_w(QUEUE_NUB)-1:0]   m_client
);

  localparam int CW = client_w(QUEUE_NUB);
  localparam int BW = $clog2(BURST + 1);

  sched_state_e    state_q, state_d;
  logic [CW-1:0]   last_grant, arb_grant, grant_d;
  logic [BW-1:0]   burst_cnt;
  logic            arb_any, keep_last, admit, load_grant, push, pop;
  logic [1:0]      occ;
  logic            rd_ptr, wr_ptr;
  logic [DATA_WIDTH-1:0] buf_data   [2];
  logic [CW-1:0]         buf_client [2];

  rr_arbiter #(.N(QUEUE_NUB), .CW(CW)) u_arb (
    .req        (~voq_queue_empty),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any_valid  (arb_any)
  );

  assign keep_last = (burst_cnt < BW'(BURST)) && !voq_queue_empty[last_grant];
  assign grant_d   = keep_last ? last_grant : arb_grant;
  assign admit     = arb_any && (occ != 2'd2);

  always_comb begin
    state_d    = state_q;
    load_grant = 1'b0;
    voq_rd_en  = 1'b0;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (admit) begin
          state_d    = ST_READ;
          load_grant = 1'b1;
        end
      end
      ST_READ: begin
        voq_rd_en = 1'b1;
        state_d   = ST_POP;
      end
      ST_POP: begin
        push    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A rotation restarts the burst count; the READ cycle then counts the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant    <= CW'(QUEUE_NUB - 1);
      burst_cnt     <= '0;
      voq_rd_client <= '0;
    end else begin
      if (load_grant) begin
        voq_rd_client <= grant_d;
        if (!keep_last) burst_cnt <= '0;
      end
      if (voq_rd_en) begin
        last_grant <= voq_rd_client;
        if (burst_cnt != BW'(BURST)) burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  assign pop      = m_valid && m_ready;
  assign m_valid  = (occ != 2'd0);
  assign m_data   = buf_data[rd_ptr];
  assign m_client = buf_client[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i]   <= '0;
        buf_client[i] <= '0;
      end
    end else begin
      if (push) begin
        buf_data[wr_ptr]   <= voq_rd_data;
        buf_client[wr_ptr] <= voq_rd_client;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule
